// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction fetch front end.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_PLUS4  = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural PC register: synchronous reset plus hold / PC+4 / target load mux.
module pc_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_t     sel,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_PLUS4:  pc <= pc_plus4;
        PC_TARGET: pc <= target;
        default:   pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch: issues one imem request per PC, buffers the
// returned word for decode, squashes in-flight data on redirect and counts deliveries.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fetch_count,
  output fetch_state_t    dbg_state
);

  // Handshakes: instr is transferred on a cycle where instr_valid && instr_ready;
  // instr/instr_pc hold steady while instr_valid is high and not yet accepted.
  // imem_req is a one-cycle strobe accepted unconditionally; exactly one
  // imem_rvalid answers each request, at least one cycle later.

  fetch_state_t state;
  pc_sel_t      pc_sel;
  logic         pending;
  logic         redirect_ok;
  logic         redirect_bad;
  logic         rsp;

  assign redirect_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign rsp          = imem_rvalid && pending;

  assign imem_req  = (state == ST_FETCH) && !rst;
  assign imem_addr = PC;
  assign dbg_state = state;

  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_ok) begin
      pc_sel = PC_TARGET;
    end else if ((state == ST_WAIT) && rsp) begin
      pc_sel = PC_PLUS4;
    end
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .sel      (pc_sel),
    .pc_plus4 (PCPlus4),
    .target   (redirect_target),
    .pc       (PC)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_FETCH;
      pending          <= 1'b0;
      instr_valid      <= 1'b0;
      instr            <= '0;
      instr_pc         <= '0;
      misaligned_fault <= 1'b0;
      fetch_count      <= '0;
    end else begin
      misaligned_fault <= redirect_bad;
      if (rsp) begin
        pending <= 1'b0;
      end
      case (state)
        ST_FETCH: begin
          pending <= 1'b1;
          // A redirect here still leaves the just-issued request in flight.
          state   <= redirect_ok ? ST_DROP : ST_WAIT;
        end
        ST_WAIT: begin
          if (redirect_ok) begin
            state <= rsp ? ST_FETCH : ST_DROP;
          end else if (rsp) begin
            instr       <= imem_rdata;
            instr_pc    <= PC;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_ok) begin
            instr_valid <= 1'b0;
            state       <= ST_FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (rsp) begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit against a transaction-level fetch model and memory responder.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_ready;
  logic         misaligned_fault;
  logic [31:0]  fetch_count;
  fetch_state_t dbg_state;

  pc_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .PC               (pc),
    .PCPlus4          (pc_plus4),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .misaligned_fault (misaligned_fault),
    .fetch_count      (fetch_count),
    .dbg_state        (dbg_state)
  );

  // The PC+4 adder downstream of the fetch unit.
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus controls.
  logic        drv_rst = 1'b1;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_tgt = 32'h0;
  logic        drv_ready = 1'b1;
  int          lat_cfg = 0;
  logic        data_fixed = 1'b0;
  logic [31:0] data_cfg = 32'h0;

  // Memory responder.
  logic        mem_busy = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_data = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  // Reference model: buffer occupancy, in-flight request and whether its data is wanted.
  logic [31:0] m_pc, m_bi, m_bp, m_cnt;
  logic        m_have, m_outst, m_want, m_mis;
  logic        check_en = 1'b0;

  // Samples of the DUT outputs for the current cycle.
  logic [31:0] s_pc, s_addr, s_instr, s_ipc, s_cnt, s_state;
  logic        s_req, s_valid, s_mis;
  logic        seen_dead = 1'b0;

  task automatic model_update();
    logic        ok;
    logic        req;
    logic        rv;
    logic [31:0] n_pc;
    logic        n_have, n_outst, n_want;
    if (drv_rst) begin
      m_pc = RESET_PC_DEFAULT; m_have = 1'b0; m_outst = 1'b0; m_want = 1'b0;
      m_bi = 32'h0; m_bp = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
    end else begin
      ok      = drv_redir && (drv_tgt[1:0] == 2'b00);
      m_mis   = drv_redir && (drv_tgt[1:0] != 2'b00);
      req     = !m_have && !m_outst;
      rv      = mem_rvalid && m_outst;
      n_pc    = m_pc;
      n_have  = m_have;
      n_outst = m_outst;
      n_want  = m_want;
      if (m_have && drv_ready && !ok) begin
        n_have = 1'b0;
        m_cnt  = m_cnt + 32'd1;
      end
      if (rv) begin
        n_outst = 1'b0;
        if (m_want && !ok) begin
          n_have = 1'b1;
          m_bi   = mem_rdata;
          m_bp   = m_pc;
          n_pc   = m_pc + 32'd4;
        end
      end
      if (req) begin
        n_outst = 1'b1;
        n_want  = 1'b1;
      end
      if (ok) begin
        n_pc   = drv_tgt;
        n_have = 1'b0;
        n_want = 1'b0;
      end
      m_pc = n_pc; m_have = n_have; m_outst = n_outst; m_want = n_want;
    end
  endtask

  // One clock cycle: apply inputs after a falling edge, sample and compare, then advance.
  task automatic run_cycle();
    rst             = drv_rst;
    redirect_valid  = drv_redir;
    redirect_target = drv_tgt;
    instr_ready     = drv_ready;
    mem_rvalid      = 1'b0;
    if (drv_rst) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_delay--;
      if (mem_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_busy   = 1'b0;
      end
    end
    mem_rdata   = mem_rvalid ? mem_data : $urandom;
    imem_rvalid = mem_rvalid;
    imem_rdata  = mem_rdata;
    #1;
    s_pc = pc; s_addr = imem_addr; s_instr = instr; s_ipc = instr_pc; s_cnt = fetch_count;
    s_req = imem_req; s_valid = instr_valid; s_mis = misaligned_fault; s_state = 32'(dbg_state);
    if (check_en) begin
      check_eq("pc", s_pc, m_pc);
      check_eq("imem_req", 32'(s_req), 32'(!m_have && !m_outst && !drv_rst));
      if (s_req) check_eq("imem_addr", s_addr, m_pc);
      check_eq("instr_valid", 32'(s_valid), 32'(m_have));
      check_eq("instr", s_instr, m_bi);
      check_eq("instr_pc", s_ipc, m_bp);
      check_eq("misaligned_fault", 32'(s_mis), 32'(m_mis));
      check_eq("fetch_count", s_cnt, m_cnt);
    end
    if (s_valid && (s_instr == 32'hDEAD_BEEF)) seen_dead = 1'b1;
    if ((imem_req === 1'b1) && !drv_rst) begin
      mem_busy  = 1'b1;
      mem_delay = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
      mem_data  = data_fixed ? data_cfg : $urandom;
    end
    @(posedge clk);
    model_update();
    if (drv_rst) check_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_for_fetch(input string tag);
    int guard = 0;
    drv_ready = 1'b1;
    while ((m_have || m_outst) && guard < 20) begin
      run_cycle();
      guard++;
    end
    check_eq(tag, 32'(!m_have && !m_outst), 32'd1);
  endtask

  logic [31:0] cnt0, instr0, pc_before;
  logic [31:0] r;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; instr_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset state.
    drv_rst = 1'b1;
    repeat (3) run_cycle();
    check_eq("rst_pc", s_pc, RESET_PC_DEFAULT);
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_count", s_cnt, 32'd0);
    check_eq("rst_req", 32'(s_req), 32'd0);

    // 1: first fetch with one-cycle memory.
    drv_rst = 1'b0; lat_cfg = 1; data_fixed = 1'b1; data_cfg = 32'h0050_0093; drv_ready = 1'b1;
    run_cycle();
    check_eq("t1_req_c0", 32'(s_req), 32'd1);
    check_eq("t1_addr_c0", s_addr, 32'h0);
    run_cycle();
    check_eq("t1_valid_c1", 32'(s_valid), 32'd0);
    run_cycle();
    check_eq("t1_valid_c2", 32'(s_valid), 32'd1);
    check_eq("t1_instr_c2", s_instr, 32'h0050_0093);
    check_eq("t1_ipc_c2", s_ipc, 32'h0);
    run_cycle();
    check_eq("t1_pc_c3", s_pc, 32'h4);
    check_eq("t1_count_c3", s_cnt, 32'd1);

    // 2: backpressure in HOLD.
    data_fixed = 1'b0; drv_ready = 1'b0;
    for (int i = 0; i < 10 && !m_have; i++) run_cycle();
    check_eq("t2_reach_hold", 32'(m_have), 32'd1);
    cnt0 = m_cnt; instr0 = m_bi;
    repeat (5) begin
      run_cycle();
      check_eq("t2_no_req", 32'(s_req), 32'd0);
    end
    check_eq("t2_cnt_held", s_cnt, cnt0);
    check_eq("t2_instr_held", s_instr, instr0);
    drv_ready = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("t2_cnt_after", s_cnt, cnt0 + 32'd1);

    // 3: redirect while waiting; the in-flight word must never reach decode.
    wait_for_fetch("t3_reach_fetch");
    seen_dead = 1'b0; lat_cfg = 3; data_fixed = 1'b1; data_cfg = 32'hDEAD_BEEF;
    run_cycle();
    data_fixed = 1'b0; lat_cfg = 1;
    drv_redir = 1'b1; drv_tgt = 32'h0000_0100;
    run_cycle();
    drv_redir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_cycle();
      if (s_req) break;
    end
    check_eq("t3_req", 32'(s_req), 32'd1);
    check_eq("t3_addr", s_addr, 32'h0000_0100);
    repeat (4) run_cycle();
    check_eq("t3_no_deadbeef", 32'(seen_dead), 32'd0);

    // 4: redirect in the same cycle as the response.
    wait_for_fetch("t4_reach_fetch");
    lat_cfg = 1;
    run_cycle();
    drv_redir = 1'b1; drv_tgt = 32'h0000_0040;
    run_cycle();
    drv_redir = 1'b0;
    run_cycle();
    check_eq("t4_req", 32'(s_req), 32'd1);
    check_eq("t4_addr", s_addr, 32'h0000_0040);
    check_eq("t4_valid", 32'(s_valid), 32'd0);

    // 5: misaligned redirect is flagged and ignored.
    wait_for_fetch("t5_reach_fetch");
    drv_ready = 1'b0;
    run_cycle();
    run_cycle();
    pc_before = m_pc;
    drv_redir = 1'b1; drv_tgt = 32'h0000_0102;
    run_cycle();
    drv_redir = 1'b0;
    run_cycle();
    check_eq("t5_fault", 32'(s_mis), 32'd1);
    check_eq("t5_pc", s_pc, pc_before);
    check_eq("t5_valid", 32'(s_valid), 32'd1);
    run_cycle();
    check_eq("t5_fault_end", 32'(s_mis), 32'd0);
    drv_ready = 1'b1;

    // 6: reset while holding the eighth instruction with fetch_count=7.
    drv_rst = 1'b1;
    run_cycle();
    drv_rst = 1'b0; lat_cfg = 0;
    for (int i = 0; i < 200 && !(m_cnt == 32'd7 && m_have); i++) begin
      drv_ready = (m_cnt < 32'd7);
      run_cycle();
    end
    check_eq("t6_reach_hold7", 32'(m_cnt == 32'd7 && m_have), 32'd1);
    drv_rst = 1'b1;
    run_cycle();
    drv_rst = 1'b0;
    run_cycle();
    check_eq("t6_pc", s_pc, RESET_PC_DEFAULT);
    check_eq("t6_valid", 32'(s_valid), 32'd0);
    check_eq("t6_count", s_cnt, 32'd0);
    check_eq("t6_state", s_state, 32'(ST_FETCH));
    check_eq("t6_req", 32'(s_req), 32'd1);

    // Randomised traffic, including the wrap at the top of the address space.
    drv_redir = 1'b0; drv_tgt = 32'hFFFF_FFFC;
    drv_redir = 1'b1;
    run_cycle();
    drv_redir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      drv_rst   = ($urandom_range(0, 199) == 0);
      drv_ready = ($urandom_range(0, 9) < 6);
      drv_redir = ($urandom_range(0, 9) == 0);
      r = 32'($urandom_range(0, 7));
      if (r == 32'd0) drv_tgt = 32'hFFFF_FFFC;
      else if (r == 32'd1) drv_tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else drv_tgt = $urandom & 32'hFFFF_FFFC;
      run_cycle();
    end
    drv_rst = 1'b0; drv_redir = 1'b0;
    repeat (4) run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
